// File: rtl/ll_multi_queue_if.sv
// ll_multi_queue_if: push/pop handshake and status bundle for ll_multi_queue.
// Handshake rule: a push (pop) transfers on the rising clock edge where
// push_valid & push_ready (pop_valid & pop_ready) are both high; ready never
// depends on valid, and a valid held while ready is low is a protocol error.
interface ll_multi_queue_if #(
  parameter int NUM_ELEMS  = 8,
  parameter int NUM_LISTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(NUM_ELEMS + 1),
  parameter int LIST_WIDTH = (NUM_LISTS > 1 ? $clog2(NUM_LISTS) : 1)
);
  logic                            push_valid;
  logic [LIST_WIDTH-1:0]           push_list;
  logic [DATA_WIDTH-1:0]           push_data;
  logic                            push_ready;
  logic                            pop_valid;
  logic [LIST_WIDTH-1:0]           pop_list;
  logic [DATA_WIDTH-1:0]           pop_data;
  logic                            pop_ready;
  logic [NUM_LISTS-1:0]            empty;
  logic                            full;
  logic [CNT_WIDTH-1:0]            total_count;
  logic [NUM_LISTS*CNT_WIDTH-1:0]  list_count;
  logic                            err_overflow;
  logic                            err_underflow;

  modport master (
    output push_valid, push_list, push_data, pop_valid, pop_list,
    input  push_ready, pop_data, pop_ready, empty, full, total_count,
           list_count, err_overflow, err_underflow
  );

  modport slave (
    input  push_valid, push_list, push_data, pop_valid, pop_list,
    output push_ready, pop_data, pop_ready, empty, full, total_count,
           list_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/ll_multi_queue.sv
// ll_multi_queue: NUM_LISTS FIFO queues built as linked lists over one shared
// pool of NUM_ELEMS payload nodes, with an internally maintained free list.
// Optional macro LL_MULTI_QUEUE_STICKY_ERR_EN: error flags latch until reset
// instead of pulsing for one cycle.
module ll_multi_queue #(
  parameter int NUM_ELEMS  = 8,
  parameter int NUM_LISTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int CNT_WIDTH  = $clog2(NUM_ELEMS + 1),
  parameter int LIST_WIDTH = (NUM_LISTS > 1 ? $clog2(NUM_LISTS) : 1)
) (
  input  logic            clk,
  input  logic            rst,
  ll_multi_queue_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]  FULL_CNT     = CNT_WIDTH'(NUM_ELEMS);
  localparam logic [CNT_WIDTH-1:0]  ONE_FREE_CNT = CNT_WIDTH'(NUM_ELEMS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [LIST_WIDTH:0]   LIST_LIMIT   = (LIST_WIDTH + 1)'(NUM_LISTS);

  // Node storage: payload (never reset) and next-pointer links.
  logic [DATA_WIDTH-1:0] r_data [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  r_next [NUM_ELEMS];

  // Per-list bookkeeping.
  logic [PTR_WIDTH-1:0]  r_head [NUM_LISTS];
  logic [PTR_WIDTH-1:0]  r_tail [NUM_LISTS];
  logic [CNT_WIDTH-1:0]  r_cnt  [NUM_LISTS];

  // Free list and global occupancy.
  logic [PTR_WIDTH-1:0]  r_free_head;
  logic [PTR_WIDTH-1:0]  r_free_tail;
  logic [CNT_WIDTH-1:0]  r_total;

  logic                  r_err_ovf;
  logic                  r_err_udf;

  logic                  w_push_list_ok;
  logic                  w_pop_list_ok;
  logic                  w_full;
  logic                  w_push_ready;
  logic                  w_pop_ready;
  logic                  w_push_fire;
  logic                  w_pop_fire;
  logic                  w_same_list;
  logic [PTR_WIDTH-1:0]  w_alloc;
  logic [PTR_WIDTH-1:0]  w_pop_node;
  logic [CNT_WIDTH-1:0]  w_push_cnt;
  logic [CNT_WIDTH-1:0]  w_pop_cnt;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [NUM_LISTS-1:0]  w_empty;
  logic [NUM_LISTS*CNT_WIDTH-1:0] w_list_count;

  // Handshake decode: readiness, fire strobes and error events.
  always_comb begin
    w_push_list_ok = ({1'b0, bus.push_list} < LIST_LIMIT);
    w_pop_list_ok  = ({1'b0, bus.pop_list} < LIST_LIMIT);
    w_full         = (r_total == FULL_CNT);
    w_push_ready   = !w_full;
    w_push_cnt     = r_cnt[bus.push_list];
    w_pop_cnt      = r_cnt[bus.pop_list];
    w_pop_node     = r_head[bus.pop_list];
    w_alloc        = r_free_head;
    w_pop_ready    = w_pop_list_ok && (w_pop_cnt != '0);
    w_push_fire    = bus.push_valid && w_push_ready && w_push_list_ok;
    w_pop_fire     = bus.pop_valid && w_pop_ready;
    w_same_list    = (bus.push_list == bus.pop_list);
    w_ovf_evt      = bus.push_valid && !w_push_fire;
    w_udf_evt      = bus.pop_valid && !w_pop_ready;
  end

  // Per-list status flattening for the packed outputs.
  always_comb begin
    w_empty      = '0;
    w_list_count = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      w_empty[i]                           = (r_cnt[i] == '0);
      w_list_count[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
    end
  end

  // Payload write for the node taken from the free list.
  always_ff @(posedge clk) begin
    if (w_push_fire) r_data[w_alloc] <= bus.push_data;
  end

  // Link, list and free-list maintenance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_ELEMS; j++) r_next[j] <= PTR_WIDTH'((j + 1) % NUM_ELEMS);
      for (int i = 0; i < NUM_LISTS; i++) begin
        r_head[i] <= '0;
        r_tail[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_free_head <= '0;
      r_free_tail <= PTR_WIDTH'(NUM_ELEMS - 1);
      r_total     <= '0;
    end else begin
      // Pop advances the head; a same-list push below may override it.
      if (w_pop_fire) r_head[bus.pop_list] <= r_next[w_pop_node];

      // Push appends the new node; an empty list, or a one-entry list that
      // is popped this same cycle, ends up holding only the new node.
      if (w_push_fire) begin
        if ((w_push_cnt == '0) || (w_pop_fire && w_same_list && (w_push_cnt == CNT_ONE)))
          r_head[bus.push_list] <= w_alloc;
        else
          r_next[r_tail[bus.push_list]] <= w_alloc;
        r_tail[bus.push_list] <= w_alloc;
      end

      // Free list: popped node joins at the tail, allocated node leaves the head.
      // When the free list is (or becomes) empty, the popped node stands alone.
      if (w_pop_fire && w_push_fire) begin
        if (r_total == ONE_FREE_CNT) begin
          r_free_head <= w_pop_node;
          r_free_tail <= w_pop_node;
        end else begin
          r_free_head         <= r_next[r_free_head];
          r_next[r_free_tail] <= w_pop_node;
          r_free_tail         <= w_pop_node;
        end
      end else if (w_pop_fire) begin
        if (w_full) begin
          r_free_head <= w_pop_node;
          r_free_tail <= w_pop_node;
        end else begin
          r_next[r_free_tail] <= w_pop_node;
          r_free_tail         <= w_pop_node;
        end
      end else if (w_push_fire) begin
        r_free_head <= r_next[r_free_head];
      end

      for (int i = 0; i < NUM_LISTS; i++) begin
        if (w_push_fire && (bus.push_list == LIST_WIDTH'(i)) &&
            !(w_pop_fire && (bus.pop_list == LIST_WIDTH'(i))))
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        else if (w_pop_fire && (bus.pop_list == LIST_WIDTH'(i)) &&
                 !(w_push_fire && (bus.push_list == LIST_WIDTH'(i))))
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
      end

      if (w_push_fire && !w_pop_fire)      r_total <= r_total + CNT_ONE;
      else if (w_pop_fire && !w_push_fire) r_total <= r_total - CNT_ONE;
    end
  end

  // Protocol error flags: one-cycle pulses, or latched until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
`ifdef LL_MULTI_QUEUE_STICKY_ERR_EN
      r_err_ovf <= r_err_ovf | w_ovf_evt;
      r_err_udf <= r_err_udf | w_udf_evt;
`else
      r_err_ovf <= w_ovf_evt;
      r_err_udf <= w_udf_evt;
`endif
    end
  end

  assign bus.push_ready    = w_push_ready;
  assign bus.pop_ready     = w_pop_ready;
  assign bus.pop_data      = r_data[w_pop_node];
  assign bus.empty         = w_empty;
  assign bus.full          = w_full;
  assign bus.total_count   = r_total;
  assign bus.list_count    = w_list_count;
  assign bus.err_overflow  = r_err_ovf;
  assign bus.err_underflow = r_err_udf;

endmodule

// File: tb/tb_ll_multi_queue.sv
// tb_ll_multi_queue: directed and random push/pop traffic on ll_multi_queue,
// checked against per-list queues of expected payloads.
module tb_ll_multi_queue;
  localparam int NE = 8;
  localparam int NL = 4;
  localparam int DW = 8;
  localparam int CW = $clog2(NE + 1);
  localparam int LW = (NL > 1 ? $clog2(NL) : 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ll_multi_queue_if #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .DATA_WIDTH(DW)) u_if ();

  ll_multi_queue #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [NL][$];
  logic          m_ovf;
  logic          m_udf;
  int            n_vec;
  int            n_err;

  function automatic int model_total();
    int s;
    s = 0;
    for (int i = 0; i < NL; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int tot;
    tot = model_total();
    check("total_count", 32'(u_if.total_count), 32'(tot));
    check("full", 32'(u_if.full), 32'(tot == NE));
    for (int i = 0; i < NL; i++) begin
      check($sformatf("list_count[%0d]", i),
            32'(u_if.list_count[i*CW +: CW]), 32'(exp_q[i].size()));
      check($sformatf("empty[%0d]", i), 32'(u_if.empty[i]), 32'(exp_q[i].size() == 0));
    end
    check("err_overflow", 32'(u_if.err_overflow), 32'(m_ovf));
    check("err_underflow", 32'(u_if.err_underflow), 32'(m_udf));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the next rising edge.
  task automatic cycle(input logic pv, input logic [LW-1:0] pl, input logic [DW-1:0] pd,
                       input logic ppv, input logic [LW-1:0] ppl);
    int   tot;
    logic exp_push_rdy, exp_pop_rdy, push_fire, pop_fire;
    u_if.push_valid = pv;
    u_if.push_list  = pl;
    u_if.push_data  = pd;
    u_if.pop_valid  = ppv;
    u_if.pop_list   = ppl;
    @(negedge clk);
    tot          = model_total();
    exp_push_rdy = (tot < NE);
    exp_pop_rdy  = (int'(ppl) < NL) && (exp_q[ppl].size() > 0);
    check("push_ready", 32'(u_if.push_ready), 32'(exp_push_rdy));
    check("pop_ready", 32'(u_if.pop_ready), 32'(exp_pop_rdy));
    if (exp_pop_rdy) check("pop_data", 32'(u_if.pop_data), 32'(exp_q[ppl][0]));
    push_fire = pv && exp_push_rdy && (int'(pl) < NL);
    pop_fire  = ppv && exp_pop_rdy;
    @(posedge clk);
    #1;
    if (pop_fire) void'(exp_q[ppl].pop_front());
    if (push_fire) exp_q[pl].push_back(pd);
`ifdef LL_MULTI_QUEUE_STICKY_ERR_EN
    m_ovf = m_ovf | (pv && !push_fire);
    m_udf = m_udf | (ppv && !exp_pop_rdy);
`else
    m_ovf = pv && !push_fire;
    m_udf = ppv && !exp_pop_rdy;
`endif
    u_if.push_valid = 1'b0;
    u_if.pop_valid  = 1'b0;
    check_state();
  endtask

  task automatic push(input logic [LW-1:0] l, input logic [DW-1:0] d);
    cycle(1'b1, l, d, 1'b0, '0);
  endtask

  task automatic pop(input logic [LW-1:0] l);
    cycle(1'b0, '0, '0, 1'b1, l);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic drain();
    for (int l = 0; l < NL; l++) begin
      while (exp_q[l].size() > 0) pop(LW'(l));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NL; i++) exp_q[i].delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    u_if.push_valid = 1'b0;
    u_if.push_list  = '0;
    u_if.push_data  = '0;
    u_if.pop_valid  = 1'b0;
    u_if.pop_list   = '0;
    clear_model();

    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    check_state();
    check("reset_push_ready", 32'(u_if.push_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three payloads through list 2 in order.
    push(2, 8'hA1);
    push(2, 8'hA2);
    push(2, 8'hA3);
    pop(2);
    pop(2);
    pop(2);
    idle();

    // Fill the pool alternating lists 0/1, then overflow and node reuse.
    for (int i = 0; i < NE; i++) push(LW'(i % 2), DW'(8'h30 + i));
    push(2, 8'h55);
    idle();
    pop(0);
    push(3, 8'h66);
    pop(3);
    // Push and pop together at seven entries: occupancy holds.
    cycle(1'b1, 1, 8'h77, 1'b1, 0);
    push(2, 8'h88);
    drain();

    // Same-list push and pop on a one-entry list.
    push(3, 8'h10);
    cycle(1'b1, 3, 8'h20, 1'b1, 3);
    pop(3);
    idle();

    // Pop an empty list: underflow flag.
    pop(1);
    idle();
    idle();

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) push(LW'(i % NL), DW'(8'hC0 + i));
    #2 rst = 1'b1;
    #1;
    clear_model();
    check_state();
    check("async_reset_push_ready", 32'(u_if.push_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) push(LW'($urandom_range(0, NL - 1)), DW'($urandom));
    drain();

    // Random traffic: push-heavy phase then pop-heavy phase.
    for (int k = 0; k < 600; k++) begin
      int pp;
      pp = (k < 300) ? 70 : 30;
      cycle($urandom_range(0, 99) < pp, LW'($urandom_range(0, NL - 1)), DW'($urandom),
            $urandom_range(0, 99) < 50, LW'($urandom_range(0, NL - 1)));
    end
    drain();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ll_multi_queue.md
Name: ll_multi_queue

Overview:
- NUM_LISTS FIFO queues sharing one pool of NUM_ELEMS storage nodes. Each node holds a DATA_WIDTH payload and a next pointer.
- Each list keeps its own head, tail and count. Unused nodes sit on a free list that the block maintains itself.
- Next generation of the pointer-only list block:
  - carries payload data;
  - uses encoded list selects with valid/ready handshakes;
  - allows push and pop on different lists, or the same list, in one cycle;
  - flags protocol errors instead of leaving them undefined.
- Sits between packet classifiers and per-class consumers (VOQ-style buffering).

Parameters:
- NUM_ELEMS, 8: total shared nodes; must be ≥ NUM_LISTS and ≥ 2.
- NUM_LISTS, 4: number of queues; ≥ 1.
- DATA_WIDTH, 8: payload width.
- PTR_WIDTH, $clog2(NUM_ELEMS): node pointer width.
- CNT_WIDTH, $clog2(NUM_ELEMS+1): count width.
- LIST_WIDTH, (NUM_LISTS>1 ? $clog2(NUM_LISTS) : 1): list select width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- push_valid  in  1  push request.
- push_list  in  LIST_WIDTH  target list for push.
- push_data  in  DATA_WIDTH  payload to append.
- push_ready  out  1  high when a push can be accepted; equals !full.
- pop_valid  in  1  pop request.
- pop_list  in  LIST_WIDTH  list to pop from.
- pop_data  out  DATA_WIDTH  payload at the head of pop_list (combinational, first-word fall-through).
- pop_ready  out  1  high when pop_list < NUM_LISTS and that list is non-empty.
- empty  out  NUM_LISTS  bit i high when count of list i is 0.
- full  out  1  total_count == NUM_ELEMS.
- total_count  out  CNT_WIDTH  nodes in use across all lists.
- list_count  out  NUM_LISTS*CNT_WIDTH  packed per-list counts; list i at [i*CNT_WIDTH +: CNT_WIDTH].
- err_overflow  out  1  push attempted while !push_ready.
- err_underflow  out  1  pop attempted while !pop_ready.

Behaviour:
- Reset (async assert, sync release):
  - all counts 0; empty all ones; full 0; push_ready 1;
  - free list holds every node in order: free_head=0, free_tail=NUM_ELEMS-1, next[j]=j+1, next[N-1]=0;
  - head/tail registers 0; error flags 0; pop_data reflects node 0 (don't-care).
  - Payload memory is not reset.
- Reset mid-operation discards all queued data immediately.
- push_fire = push_valid & push_ready & (push_list < NUM_LISTS). pop_fire = pop_valid & pop_ready.
- Push (one cycle):
  - node n = free_head; data[n] <= push_data.
  - If list empty: head <= n. Else: next[tail] <= n.
  - tail <= n; list count +1.
- Pop (one cycle):
  - node h = head; pop_data valid in the same cycle as pop_fire.
  - head <= next[h]; count −1; h is appended to the free list tail.
- Free list update when both fire in one cycle:
  - popped node h joins the free list;
  - allocated node n leaves it;
  - when the free list has exactly one node (total_count == NUM_ELEMS-1), the new free list is h alone: free_head=free_tail=h.
- Same-list push and pop with count==1: head <= n, tail <= n, count stays 1.
- Same-list push and pop with count>1: pop updates head, push updates tail; count unchanged.
- Push with list empty and a pop on another list: handled independently.
- Count arithmetic:
  - total_count changes by push_fire − pop_fire;
  - no wrap: overflow and underflow are blocked by the handshakes.
- Full: push_ready=0, so no push-through even with a simultaneous pop. The pop still completes.
- Errors:
  - err_overflow is a 1-cycle registered pulse, the cycle after push_valid & !push_fire.
  - err_underflow is a 1-cycle registered pulse, the cycle after pop_valid & !pop_ready.
  - An erroring request changes no state.
- Invariant: sum of list counts + free-list length == NUM_ELEMS.
- Invariant: node sequences of the lists and the free list are disjoint.

Optional Feature:
- Macro: LL_MULTI_QUEUE_STICKY_ERR_EN.
- Defined: err_overflow and err_underflow latch high on the first offending request and stay high until rst.
- Undefined: single-cycle pulses as described above.

Test Plan:
- After reset, push 0xA1, 0xA2, 0xA3 to list 2 → list_count[2]=3, total_count=3, pop_data with pop_list=2 is 0xA1; three pops return 0xA1, 0xA2, 0xA3, then empty[2]=1.
- Fill all 8 nodes alternating lists 0/1 → full=1, push_ready=0. Push 0x55 → err_overflow pulses and no state changes. Pop list 0, then push 0x66 to list 3 → succeeds and the freed node is reused.
- With total_count=7, push to list 1 and pop list 0 in the same cycle → total_count stays 7. Next push succeeds, and the free list then holds exactly the popped node.
- List 3 holds a single 0x10: push 0x20 and pop list 3 in the same cycle → pop_data=0x10, list_count[3]=1, next pop returns 0x20.
- Pop list 1 while empty, and pop with pop_list=NUM_LISTS when NUM_LISTS is not a power of 2 → err_underflow pulses for 1 cycle and counts are unchanged. Repeat with LL_MULTI_QUEUE_STICKY_ERR_EN defined → flag stays high until rst.
- Assert rst asynchronously mid-stream with 5 entries queued → outputs return to reset values before the next clock edge, and 8 pushes then succeed.
